pipeline_mem_lsu: RTL and testbench
===================================

Name: pipeline_mem_lsu

Overview:
MEM stage of the 5-stage pipeline; consumes the EXE→MEM register outputs (alu result, dmem type, writeback controls).
Issues load/store requests on a valid/ready data-memory bus and aligns, sign- or zero-extends load data.
Stalls the front of the pipeline while an access is outstanding, and registers the WB-stage signals.
Sits between the EXE stage and WB stage; its stall output feeds the hazard unit, which drives the EXE stall input.

Parameters:
XLEN, 32, datapath and address width
RESET_PC, 32'h80000000, reset value of pc_instr_m_o

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
alu_result_e_i  input  32  memory address, or ALU result for writeback
store_data_e_i  input  32  rs2 store data
dmem_type_e_i  input  4  access type (encoding below)
extended_imm_e_i  input  32  lui immediate
pc_plus4_e_i  input  32  jal/jalr link value
pc_instr_e_i  input  32  instruction PC
reg_write_en_e_i  input  1  RF write enable
rd_idx_e_i  input  5  destination register
result_src_e_i  input  4  one-hot: 0001 alu, 0010 mem, 0100 imm, 1000 pc+4
instr_illegal_e_i  input  1  illegal instruction flag
flush_m_i  input  1  kill the instruction currently in MEM
dmem_req_o  output  1  request valid
dmem_we_o  output  1  1 = store
dmem_addr_o  output  32  word-aligned address ({addr[31:2],2'b00})
dmem_wdata_o  output  32  lane-replicated store data
dmem_wstrb_o  output  4  byte strobes
dmem_ready_i  input  1  request accepted this cycle
dmem_rvalid_i  input  1  load data valid
dmem_rdata_i  input  32  load data
st_m_o  output  1  stall request to hazard unit (combinational)
wb_result_m_o  output  32  selected writeback value
reg_write_en_m_o  output  1  WB write enable
rd_idx_m_o  output  5  WB destination register
pc_instr_m_o  output  32  instruction PC
instr_illegal_m_o  output  1  illegal flag passed through
misaligned_m_o  output  1  misaligned access flag, registered

Behaviour:
- dmem_type encoding: 0000 none; 0001 LB; 0010 LH; 0011 LW; 0100 LBU; 0101 LHU; 1001 SB; 1010 SH; 1011 SW. All other codes behave as none.
- Misalignment:
  - Halfword access with addr[0]=1 is misaligned.
  - Word access with addr[1:0]≠0 is misaligned.
  - A misaligned access issues no request and does not stall. It registers misaligned_m_o=1 and reg_write_en_m_o=0.
- FSM states: IDLE, WAIT, DRAIN. Reset places the FSM in IDLE.
- IDLE, aligned access present, no flush:
  - dmem_req_o=1 combinationally.
  - Store accepted (ready=1): completes in the same cycle with no stall; stays in IDLE.
  - Load accepted: go to WAIT.
  - Not accepted: stay in IDLE with the request held stable. st_m_o=1.
- WAIT:
  - st_m_o=1 until dmem_rvalid_i.
  - On rvalid: the load completes, the FSM returns to IDLE, and st_m_o=0 in that cycle.
  - rvalid in the same cycle as acceptance is ignored; the earliest response is the cycle after acceptance.
  - A zero-wait load therefore costs 1 stall cycle.
- flush_m_i:
  - In IDLE: suppresses the request and the completion, and produces a bubble.
  - In WAIT: go to DRAIN. st_m_o is deasserted.
- DRAIN:
  - Blocks new requests and holds st_m_o=1 if a new memory op is present.
  - Discards the response on rvalid and returns to IDLE.
- Store data replication:
  - SB: wdata={4{d[7:0]}}, wstrb=1<<addr[1:0].
  - SH: wdata={2{d[15:0]}}, wstrb=0011<<addr[1:0].
  - SW: wdata=d, wstrb=1111.
- Load extraction: select the byte/half lane by the address bits captured at acceptance. LB/LH sign-extend; LBU/LHU zero-extend.
- Output registers:
  - Updated on every cycle where st_m_o=0. On a stall cycle or a flush cycle they load a bubble.
  - Bubble: reg_write_en=0, misaligned=0, illegal=0, rd=0, result=0.
  - wb_result_m_o is selected by result_src; mem selects the extracted load data.
- Reset values: all outputs 0; pc_instr_m_o=RESET_PC; dmem_req_o=0.
- Reset mid-WAIT: return to IDLE; the late response is ignored.

Optional Feature:
MEM_BYPASS_EN:
- Defined: adds output bypass_m_o[31:0], equal to the combinational next wb_result value (before the output register), for EX-stage forwarding. While st_m_o=1 it holds 0.
- Undefined: the port and its logic are absent.

Test Plan:
- LW addr 0x100, ready=1, rvalid the next cycle with rdata 0xDEADBEEF -> exactly 1 stall cycle; wb_result=0xDEADBEEF, reg_write_en=1 after completion.
- LB addr 0x103 with rdata 0x80FF_FF7F -> 0xFFFFFF80. LBU at the same address -> 0x00000080.
- SH addr 0x202, data 0x1234ABCD, ready=1 -> wstrb=1100, wdata=0xABCDABCD, no stall, reg_write_en_m_o=0.
- LW addr 0x101 -> no request, misaligned_m_o=1, reg_write_en_m_o=0.
- LW accepted, flush in the first WAIT cycle, rvalid 3 cycles later -> response discarded; a following LW issues only after DRAIN returns to IDLE.
- SW with ready low for 4 cycles -> dmem_req_o and address held stable, st_m_o=1 for 4 cycles, store completes on the 5th cycle.

Source files
------------

// File: rtl/pipeline_mem_lsu.sv
// -----------------------------------------------------------------------------
// pipeline_mem_lsu - MEM stage of the 5-stage pipeline.
//
// Takes the EXE->MEM register outputs and issues loads/stores on a
// valid/ready data-memory bus. It aligns and extends load data and registers
// the WB-stage signals. While an access is outstanding it raises st_m_o
// (combinational) to the hazard unit, which holds the EXE->MEM register stable.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   *_e_i                 EXE->MEM register outputs (address/ALU result, store
//                         data, access type, lui imm, link value, PC, WB ctrl)
//   flush_m_i             kill the instruction currently in MEM
//   dmem_req_o/we/addr/wdata/wstrb, dmem_ready_i   request channel
//   dmem_rvalid_i/rdata_i                          load response channel
//   st_m_o                stall request to the hazard unit
//   *_m_o                 registered MEM->WB signals
//
// Optional feature (macro MEM_BYPASS_EN): adds bypass_m_o, the unregistered
// next wb_result for EX-stage forwarding, forced to 0 while stalling.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module pipeline_mem_lsu #(
    parameter int          XLEN     = 32,
    parameter logic [31:0] RESET_PC = 32'h80000000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] alu_result_e_i,
    input  logic [XLEN-1:0] store_data_e_i,
    input  logic [3:0]      dmem_type_e_i,
    input  logic [XLEN-1:0] extended_imm_e_i,
    input  logic [XLEN-1:0] pc_plus4_e_i,
    input  logic [XLEN-1:0] pc_instr_e_i,
    input  logic            reg_write_en_e_i,
    input  logic [4:0]      rd_idx_e_i,
    input  logic [3:0]      result_src_e_i,
    input  logic            instr_illegal_e_i,
    input  logic            flush_m_i,
    output logic            dmem_req_o,
    output logic            dmem_we_o,
    output logic [XLEN-1:0] dmem_addr_o,
    output logic [XLEN-1:0] dmem_wdata_o,
    output logic [3:0]      dmem_wstrb_o,
    input  logic            dmem_ready_i,
    input  logic            dmem_rvalid_i,
    input  logic [XLEN-1:0] dmem_rdata_i,
    output logic            st_m_o,
    output logic [XLEN-1:0] wb_result_m_o,
    output logic            reg_write_en_m_o,
    output logic [4:0]      rd_idx_m_o,
    output logic [XLEN-1:0] pc_instr_m_o,
    output logic            instr_illegal_m_o,
    output logic            misaligned_m_o
`ifdef MEM_BYPASS_EN
    ,
    output logic [XLEN-1:0] bypass_m_o
`endif
);

    typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_e;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_e;

    state_e          state_q, state_d;
    size_e           size, ld_size_q;
    logic            is_load, is_store, ld_uns, ld_uns_q;
    logic [1:0]      ld_off_q;
    logic            misaligned, mem_op;
    logic            complete, capture;
    logic [XLEN-1:0] rdata_sh, load_ext;
    logic [XLEN-1:0] wb_result_d, wb_result_q, pc_instr_q;
    logic            reg_write_en_d, reg_write_en_q;
    logic [4:0]      rd_idx_d, rd_idx_q;
    logic            illegal_d, illegal_q, misaligned_d, misaligned_q;

    // Access-type decode; unlisted codes fall through as "no access".
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        ld_uns   = 1'b0;
        size     = SZ_B;
        case (dmem_type_e_i)
            4'b0001: begin is_load  = 1'b1; size = SZ_B; end
            4'b0010: begin is_load  = 1'b1; size = SZ_H; end
            4'b0011: begin is_load  = 1'b1; size = SZ_W; end
            4'b0100: begin is_load  = 1'b1; size = SZ_B; ld_uns = 1'b1; end
            4'b0101: begin is_load  = 1'b1; size = SZ_H; ld_uns = 1'b1; end
            4'b1001: begin is_store = 1'b1; size = SZ_B; end
            4'b1010: begin is_store = 1'b1; size = SZ_H; end
            4'b1011: begin is_store = 1'b1; size = SZ_W; end
            default: ;
        endcase
    end

    assign misaligned = (is_load | is_store) &
                        (((size == SZ_H) & alu_result_e_i[0]) |
                         ((size == SZ_W) & (|alu_result_e_i[1:0])));
    assign mem_op     = (is_load | is_store) & ~misaligned & ~flush_m_i;

    // Control FSM. "complete" means the instruction in MEM retires into the
    // WB register this cycle; otherwise a bubble is loaded.
    always_comb begin
        state_d    = state_q;
        dmem_req_o = 1'b0;
        st_m_o     = 1'b0;
        complete   = 1'b0;
        capture    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!flush_m_i) begin
                    if (mem_op) begin
                        dmem_req_o = 1'b1;
                        if (dmem_ready_i && is_store) begin
                            complete = 1'b1;
                        end else if (dmem_ready_i) begin
                            capture = 1'b1;
                            st_m_o  = 1'b1;
                            state_d = WAIT;
                        end else begin
                            st_m_o = 1'b1;
                        end
                    end else begin
                        complete = 1'b1;
                    end
                end
            end
            WAIT: begin
                // A flushed load must still see its response before the bus
                // is reused, unless the response arrives in the flush cycle.
                if (flush_m_i) begin
                    state_d = dmem_rvalid_i ? IDLE : DRAIN;
                end else if (dmem_rvalid_i) begin
                    complete = 1'b1;
                    state_d  = IDLE;
                end else begin
                    st_m_o = 1'b1;
                end
            end
            DRAIN: begin
                if (dmem_rvalid_i) state_d = IDLE;
                if (mem_op)            st_m_o   = 1'b1;
                else if (!flush_m_i)   complete = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Request channel; everything is zero when no request is presented.
    always_comb begin
        dmem_we_o    = 1'b0;
        dmem_addr_o  = '0;
        dmem_wdata_o = '0;
        dmem_wstrb_o = 4'b0000;
        if (dmem_req_o) begin
            dmem_we_o   = is_store;
            dmem_addr_o = {alu_result_e_i[XLEN-1:2], 2'b00};
            if (is_store) begin
                case (size)
                    SZ_B: begin
                        dmem_wdata_o = {4{store_data_e_i[7:0]}};
                        dmem_wstrb_o = 4'b0001 << alu_result_e_i[1:0];
                    end
                    SZ_H: begin
                        dmem_wdata_o = {2{store_data_e_i[15:0]}};
                        dmem_wstrb_o = 4'b0011 << alu_result_e_i[1:0];
                    end
                    default: begin
                        dmem_wdata_o = store_data_e_i;
                        dmem_wstrb_o = 4'b1111;
                    end
                endcase
            end
        end
    end

    // Load lane extraction uses the offset/type captured at acceptance.
    assign rdata_sh = dmem_rdata_i >> {ld_off_q, 3'b000};

    always_comb begin
        case (ld_size_q)
            SZ_B:    load_ext = ld_uns_q ? {{(XLEN-8){1'b0}}, rdata_sh[7:0]}
                                         : {{(XLEN-8){rdata_sh[7]}}, rdata_sh[7:0]};
            SZ_H:    load_ext = ld_uns_q ? {{(XLEN-16){1'b0}}, rdata_sh[15:0]}
                                         : {{(XLEN-16){rdata_sh[15]}}, rdata_sh[15:0]};
            default: load_ext = dmem_rdata_i;
        endcase
    end

    // Next WB register contents; a misaligned access carries no result.
    always_comb begin
        wb_result_d    = '0;
        reg_write_en_d = 1'b0;
        rd_idx_d       = 5'd0;
        illegal_d      = 1'b0;
        misaligned_d   = 1'b0;
        if (complete) begin
            reg_write_en_d = reg_write_en_e_i & ~misaligned;
            rd_idx_d       = rd_idx_e_i;
            illegal_d      = instr_illegal_e_i;
            misaligned_d   = misaligned;
            if (!misaligned) begin
                case (result_src_e_i)
                    4'b0001: wb_result_d = alu_result_e_i;
                    4'b0010: wb_result_d = load_ext;
                    4'b0100: wb_result_d = extended_imm_e_i;
                    4'b1000: wb_result_d = pc_plus4_e_i;
                    default: wb_result_d = '0;
                endcase
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            ld_size_q      <= SZ_W;
            ld_uns_q       <= 1'b0;
            ld_off_q       <= 2'b00;
            wb_result_q    <= '0;
            reg_write_en_q <= 1'b0;
            rd_idx_q       <= 5'd0;
            illegal_q      <= 1'b0;
            misaligned_q   <= 1'b0;
            pc_instr_q     <= RESET_PC;
        end else begin
            state_q        <= state_d;
            if (capture) begin
                ld_size_q <= size;
                ld_uns_q  <= ld_uns;
                ld_off_q  <= alu_result_e_i[1:0];
            end
            wb_result_q    <= wb_result_d;
            reg_write_en_q <= reg_write_en_d;
            rd_idx_q       <= rd_idx_d;
            illegal_q      <= illegal_d;
            misaligned_q   <= misaligned_d;
            pc_instr_q     <= pc_instr_e_i;
        end
    end

    assign wb_result_m_o     = wb_result_q;
    assign reg_write_en_m_o  = reg_write_en_q;
    assign rd_idx_m_o        = rd_idx_q;
    assign pc_instr_m_o      = pc_instr_q;
    assign instr_illegal_m_o = illegal_q;
    assign misaligned_m_o    = misaligned_q;

`ifdef MEM_BYPASS_EN
    assign bypass_m_o = st_m_o ? '0 : wb_result_d;
`endif

endmodule

// File: tb/tb_pipeline_mem_lsu.sv
`timescale 1ns/1ps

module tb_pipeline_mem_lsu;

    localparam logic [31:0] RESET_PC = 32'h80000000;
    localparam logic [31:0] IMM_VAL  = 32'h000AB000;
    localparam logic [31:0] LINK_VAL = 32'h80000104;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] alu_result_e_i, store_data_e_i, extended_imm_e_i, pc_plus4_e_i, pc_instr_e_i;
    logic [3:0]  dmem_type_e_i, result_src_e_i;
    logic        reg_write_en_e_i, instr_illegal_e_i, flush_m_i;
    logic [4:0]  rd_idx_e_i;
    logic        dmem_req_o, dmem_we_o, dmem_ready_i, dmem_rvalid_i;
    logic [31:0] dmem_addr_o, dmem_wdata_o, dmem_rdata_i;
    logic [3:0]  dmem_wstrb_o;
    logic        st_m_o, reg_write_en_m_o, instr_illegal_m_o, misaligned_m_o;
    logic [31:0] wb_result_m_o, pc_instr_m_o;
    logic [4:0]  rd_idx_m_o;
`ifdef MEM_BYPASS_EN
    logic [31:0] bypass_m_o;
`endif

    always #5 clk = ~clk;

    pipeline_mem_lsu #(.XLEN(32), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .reset(reset),
        .alu_result_e_i(alu_result_e_i), .store_data_e_i(store_data_e_i),
        .dmem_type_e_i(dmem_type_e_i), .extended_imm_e_i(extended_imm_e_i),
        .pc_plus4_e_i(pc_plus4_e_i), .pc_instr_e_i(pc_instr_e_i),
        .reg_write_en_e_i(reg_write_en_e_i), .rd_idx_e_i(rd_idx_e_i),
        .result_src_e_i(result_src_e_i), .instr_illegal_e_i(instr_illegal_e_i),
        .flush_m_i(flush_m_i),
        .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
        .dmem_wdata_o(dmem_wdata_o), .dmem_wstrb_o(dmem_wstrb_o),
        .dmem_ready_i(dmem_ready_i), .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
        .st_m_o(st_m_o), .wb_result_m_o(wb_result_m_o), .reg_write_en_m_o(reg_write_en_m_o),
        .rd_idx_m_o(rd_idx_m_o), .pc_instr_m_o(pc_instr_m_o),
        .instr_illegal_m_o(instr_illegal_m_o), .misaligned_m_o(misaligned_m_o)
`ifdef MEM_BYPASS_EN
        , .bypass_m_o(bypass_m_o)
`endif
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        we;
    } bus_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] result;
        logic        mis;
        logic        ill;
        logic        chk_res;
    } wb_t;

    bus_t bus_q[$];
    wb_t  wb_q[$];
    bus_t mon_b;
    wb_t  mon_w;
    int   n_pass  = 0;
    int   n_total = 0;
    logic [31:0] pc_next = 32'h80001000;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // Scoreboard monitor: bus requests and retiring WB entries.
    always @(negedge clk) begin
        if (!reset) begin
            if (dmem_req_o && dmem_ready_i) begin
                if (bus_q.size() == 0) begin
                    check("unexpected_req", 32'(dmem_req_o), 32'd0);
                end else begin
                    mon_b = bus_q.pop_front();
                    check("bus_we", 32'(dmem_we_o), 32'(mon_b.we));
                    check("bus_addr", dmem_addr_o, mon_b.addr);
                    if (mon_b.we) begin
                        check("bus_wdata", dmem_wdata_o, mon_b.wdata);
                        check("bus_wstrb", 32'(dmem_wstrb_o), 32'(mon_b.wstrb));
                    end
                end
            end
            if (reg_write_en_m_o || misaligned_m_o) begin
                if (wb_q.size() == 0) begin
                    check("unexpected_wb", {30'd0, reg_write_en_m_o, misaligned_m_o}, 32'd0);
                end else begin
                    mon_w = wb_q.pop_front();
                    check("wb_rd", 32'(rd_idx_m_o), 32'(mon_w.rd));
                    check("wb_misaligned", 32'(misaligned_m_o), 32'(mon_w.mis));
                    check("wb_we", 32'(reg_write_en_m_o), 32'(!mon_w.mis));
                    check("wb_illegal", 32'(instr_illegal_m_o), 32'(mon_w.ill));
                    if (mon_w.chk_res) check("wb_result", wb_result_m_o, mon_w.result);
                end
            end
        end
    end

    task automatic set_idle();
        dmem_type_e_i    = 4'b0000;
        reg_write_en_e_i = 1'b0;
        instr_illegal_e_i = 1'b0;
        flush_m_i        = 1'b0;
        dmem_ready_i     = 1'b0;
        dmem_rvalid_i    = 1'b0;
        dmem_rdata_i     = 32'h0;
    endtask

    task automatic present(input logic [3:0] t, input logic [31:0] a, input logic [31:0] d,
                           input logic [4:0] rd, input logic rwe, input logic [3:0] src,
                           input logic ill);
        dmem_type_e_i     = t;
        alu_result_e_i    = a;
        store_data_e_i    = d;
        rd_idx_e_i        = rd;
        reg_write_en_e_i  = rwe;
        result_src_e_i    = src;
        instr_illegal_e_i = ill;
        pc_instr_e_i      = pc_next;
        pc_next           = pc_next + 32'd4;
    endtask

    // One instruction through MEM with a scripted memory: ready held low for
    // ready_wait cycles, response rsp_wait cycles after acceptance.
    task automatic do_op(input logic [3:0] t, input logic [31:0] a, input logic [31:0] d,
                         input logic [4:0] rd, input logic rwe, input logic [3:0] src,
                         input logic ill, input int ready_wait, input int rsp_wait,
                         input logic [31:0] rdata, input logic exp_mis,
                         input logic [31:0] exp_res, input logic [31:0] exp_wdata,
                         input logic [3:0] exp_wstrb, input int exp_stalls);
        int   waits  = 0;
        int   since  = 0;
        int   stalls = 0;
        logic acc    = 1'b0;
        logic done   = 1'b0;
        logic s_st, s_acc;
        logic [31:0] my_pc;
        my_pc = pc_next;
        present(t, a, d, rd, rwe, src, ill);
        if (t != 4'b0000 && !exp_mis)
            bus_q.push_back('{addr: {a[31:2], 2'b00}, wdata: exp_wdata, wstrb: exp_wstrb, we: t[3]});
        if (rwe || exp_mis)
            wb_q.push_back('{rd: rd, result: exp_res, mis: exp_mis, ill: ill, chk_res: !exp_mis});
        for (int c = 0; c < 40 && !done; c++) begin
            dmem_ready_i  = (waits >= ready_wait);
            dmem_rvalid_i = acc && (since == rsp_wait);
            dmem_rdata_i  = dmem_rvalid_i ? rdata : 32'hBAD0BAD0;
            @(negedge clk);
            s_st  = st_m_o;
            s_acc = dmem_req_o && dmem_ready_i;
            if (dmem_req_o && !dmem_ready_i) check("held_addr", dmem_addr_o, {a[31:2], 2'b00});
            @(posedge clk); #1;
            if (!s_st) begin
                done = 1'b1;
            end else begin
                stalls++;
                waits++;
                if (acc) since++;
                if (s_acc) begin acc = 1'b1; since = 1; end
            end
        end
        check("op_done", 32'(done), 32'd1);
        check("stall_cycles", 32'(stalls), 32'(exp_stalls));
        set_idle();
        @(negedge clk);
        check("pc_m", pc_instr_m_o, my_pc);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset            = 1'b1;
        alu_result_e_i   = '0;
        store_data_e_i   = '0;
        extended_imm_e_i = IMM_VAL;
        pc_plus4_e_i     = LINK_VAL;
        pc_instr_e_i     = '0;
        rd_idx_e_i       = '0;
        result_src_e_i   = 4'b0001;
        set_idle();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_wb_result", wb_result_m_o, 32'h0);
        check("rst_we", 32'(reg_write_en_m_o), 32'd0);
        check("rst_rd", 32'(rd_idx_m_o), 32'd0);
        check("rst_pc", pc_instr_m_o, RESET_PC);
        check("rst_mis", 32'(misaligned_m_o), 32'd0);
        check("rst_ill", 32'(instr_illegal_m_o), 32'd0);
        check("rst_req", 32'(dmem_req_o), 32'd0);
        check("rst_st", 32'(st_m_o), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // Loads: zero-wait LW, byte/half lanes with sign and zero extension.
        do_op(4'b0011, 32'h100, 0, 5'd5, 1, 4'b0010, 0, 0, 1, 32'hDEADBEEF, 0, 32'hDEADBEEF, 0, 0, 1);
        do_op(4'b0001, 32'h103, 0, 5'd6, 1, 4'b0010, 0, 0, 1, 32'h80FFFF7F, 0, 32'hFFFFFF80, 0, 0, 1);
        do_op(4'b0100, 32'h103, 0, 5'd7, 1, 4'b0010, 0, 0, 1, 32'h80FFFF7F, 0, 32'h00000080, 0, 0, 1);
        do_op(4'b0010, 32'h102, 0, 5'd8, 1, 4'b0010, 0, 0, 1, 32'h80FFFF7F, 0, 32'hFFFF80FF, 0, 0, 1);
        do_op(4'b0101, 32'h100, 0, 5'd9, 1, 4'b0010, 0, 0, 1, 32'h80FFFF7F, 0, 32'h0000FF7F, 0, 0, 1);
        do_op(4'b0011, 32'h104, 0, 5'd10, 1, 4'b0010, 0, 0, 3, 32'h01234567, 0, 32'h01234567, 0, 0, 3);

        // Stores: lane replication and strobes, and a store held by ready low.
        do_op(4'b1010, 32'h202, 32'h1234ABCD, 5'd0, 0, 4'b0001, 0, 0, 1, 0, 0, 0, 32'hABCDABCD, 4'b1100, 0);
        do_op(4'b1001, 32'h201, 32'h0000005A, 5'd0, 0, 4'b0001, 0, 0, 1, 0, 0, 0, 32'h5A5A5A5A, 4'b0010, 0);
        do_op(4'b1011, 32'h300, 32'hCAFEF00D, 5'd0, 0, 4'b0001, 0, 4, 1, 0, 0, 0, 32'hCAFEF00D, 4'b1111, 4);

        // Misaligned accesses: no request, no stall, flagged.
        do_op(4'b0011, 32'h101, 0, 5'd11, 1, 4'b0010, 0, 0, 1, 0, 1, 0, 0, 0, 0);
        do_op(4'b0010, 32'h103, 0, 5'd12, 1, 4'b0010, 0, 0, 1, 0, 1, 0, 0, 0, 0);
        do_op(4'b1011, 32'h202, 32'h55, 5'd0, 0, 4'b0001, 0, 0, 1, 0, 1, 0, 0, 0, 0);

        // Non-memory ops through each result source.
        do_op(4'b0000, 32'h11112222, 0, 5'd3, 1, 4'b0001, 0, 0, 1, 0, 0, 32'h11112222, 0, 0, 0);
        do_op(4'b0000, 32'h0, 0, 5'd4, 1, 4'b0100, 1, 0, 1, 0, 0, IMM_VAL, 0, 0, 0);
        do_op(4'b0000, 32'h0, 0, 5'd13, 1, 4'b1000, 0, 0, 1, 0, 0, LINK_VAL, 0, 0, 0);

        // Flush in the first WAIT cycle; response three cycles later is dropped
        // and the following LW waits for DRAIN to finish.
        bus_q.push_back('{addr: 32'h300, wdata: 32'h0, wstrb: 4'h0, we: 1'b0});
        present(4'b0011, 32'h300, 0, 5'd14, 1, 4'b0010, 0);
        dmem_ready_i = 1'b1;
        @(negedge clk);
        check("flush_acc_st", 32'(st_m_o), 32'd1);
        @(posedge clk); #1;
        flush_m_i = 1'b1;
        @(negedge clk);
        check("flush_wait_st", 32'(st_m_o), 32'd0);
        check("flush_wait_req", 32'(dmem_req_o), 32'd0);
        @(posedge clk); #1;
        flush_m_i = 1'b0;
        present(4'b0011, 32'h304, 0, 5'd15, 1, 4'b0010, 0);
        for (int k = 0; k < 3; k++) begin
            dmem_rvalid_i = (k == 2);
            dmem_rdata_i  = 32'h0BADBEEF;
            @(negedge clk);
            check("drain_st", 32'(st_m_o), 32'd1);
            check("drain_req", 32'(dmem_req_o), 32'd0);
            @(posedge clk); #1;
        end
        dmem_rvalid_i = 1'b0;
        do_op(4'b0011, 32'h304, 0, 5'd15, 1, 4'b0010, 0, 0, 1, 32'h76543210, 0, 32'h76543210, 0, 0, 1);

        // Flush in IDLE: no request, no stall, bubble.
        present(4'b0011, 32'h400, 0, 5'd16, 1, 4'b0010, 0);
        flush_m_i    = 1'b1;
        dmem_ready_i = 1'b1;
        @(negedge clk);
        check("flush_idle_req", 32'(dmem_req_o), 32'd0);
        check("flush_idle_st", 32'(st_m_o), 32'd0);
        @(posedge clk); #1;
        set_idle();
        @(negedge clk);
        check("flush_idle_we", 32'(reg_write_en_m_o), 32'd0);
        @(posedge clk); #1;

        // Reset while waiting: the late response is ignored.
        bus_q.push_back('{addr: 32'h500, wdata: 32'h0, wstrb: 4'h0, we: 1'b0});
        present(4'b0011, 32'h500, 0, 5'd17, 1, 4'b0010, 0);
        dmem_ready_i = 1'b1;
        @(posedge clk); #1;
        reset = 1'b1;
        set_idle();
        @(posedge clk); #1;
        reset = 1'b0;
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = 32'hFEEDFACE;
        @(negedge clk);
        check("rst_wait_st", 32'(st_m_o), 32'd0);
        check("rst_wait_pc", pc_instr_m_o, RESET_PC);
        @(posedge clk); #1;
        dmem_rvalid_i = 1'b0;
        repeat (3) @(negedge clk);
        check("bus_q_empty", 32'(bus_q.size()), 32'd0);
        check("wb_q_empty", 32'(wb_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
